// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter
//   Shares a single-port register file (one read-pair or one write per
//   clock edge) between the writeback stage (write requester) and the
//   decode stage (read requester). Writes normally win. A read that has
//   waited through MAX_WR_STREAK consecutive write grants is forced
//   through on the next cycle, so decode cannot starve.
//
//   Handshake: a transfer happens in a cycle where valid && ready are both
//   high. Ready is combinational and may depend on valid. A requester holds
//   valid and its payload stable until the transfer. Read responses are a
//   one-cycle rsp_valid pulse with no backpressure.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     wr_valid/wr_ready        writeback request / grant
//     wr_rd, wr_data           write destination and data
//     rd_valid/rd_ready        decode read request / grant
//     rd_rs1, rd_rs2           read source registers
//     rsp_valid, rsp_data1/2   read response, cycle after the read grant
//     rf_write, rf_write_data, rf_rd, rf_rs1, rf_rs2
//                              register file controls
//     rf_out1, rf_out2         register file read data (1-cycle registered)
//     state_dbg                FSM state (0 idle, 1 write, 2 read)
//
//   Optional: define RF_ARB_PERF_EN to add perf_conflict_cnt (cycles with
//   both requesters valid) and perf_force_cnt (reads forced by the write
//   streak limit). Both saturate at 16'hFFFF.
module rf_port_arbiter #(
    parameter int MAX_WR_STREAK = 4,
    parameter int STREAK_W      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [4:0]  wr_rd,
    input  logic [31:0] wr_data,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic [4:0]  rd_rs1,
    input  logic [4:0]  rd_rs2,
    output logic        rsp_valid,
    output logic [31:0] rsp_data1,
    output logic [31:0] rsp_data2,
    output logic        rf_write,
    output logic [31:0] rf_write_data,
    output logic [4:0]  rf_rd,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    input  logic [31:0] rf_out1,
    input  logic [31:0] rf_out2,
    output logic [1:0]  state_dbg
`ifdef RF_ARB_PERF_EN
    ,
    output logic [15:0] perf_conflict_cnt,
    output logic [15:0] perf_force_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_WR_STREAK);

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic                z1_q, z2_q;
    logic [4:0]          last_rs1, last_rs2;
    logic                force_rd;
    logic                wr_gnt;
    logic                rd_gnt;

    // A waiting read whose streak hit the limit blocks the write this cycle.
    assign force_rd = rd_valid && (streak == MAX_S);
    // Grants are suppressed during reset so nothing transfers in that cycle.
    assign wr_gnt   = !rst && wr_valid && !force_rd;
    assign rd_gnt   = !rst && rd_valid && !wr_gnt;

    assign wr_ready = wr_gnt;
    assign rd_ready = rd_gnt;

    // Writes to x0 are accepted but never reach the register file.
    assign rf_write      = wr_gnt && (wr_rd != 5'd0);
    assign rf_rd         = wr_gnt ? wr_rd   : 5'd0;
    assign rf_write_data = wr_gnt ? wr_data : 32'd0;
    // Read addresses hold between reads so rf_out stays meaningful.
    assign rf_rs1        = rd_gnt ? rd_rs1 : last_rs1;
    assign rf_rs2        = rd_gnt ? rd_rs2 : last_rs2;

    assign rsp_valid = (state == ST_READ);
    assign rsp_data1 = (rsp_valid && !z1_q) ? rf_out1 : 32'd0;
    assign rsp_data2 = (rsp_valid && !z2_q) ? rf_out2 : 32'd0;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            streak   <= '0;
            z1_q     <= 1'b0;
            z2_q     <= 1'b0;
            last_rs1 <= 5'd0;
            last_rs2 <= 5'd0;
        end else begin
            if (wr_gnt)      state <= ST_WRITE;
            else if (rd_gnt) state <= ST_READ;
            else             state <= ST_IDLE;

            // Streak only measures writes that overtook a waiting read.
            if (!rd_valid || rd_gnt)
                streak <= '0;
            else if (wr_gnt && streak != MAX_S)
                streak <= streak + 1'b1;

            if (rd_gnt) begin
                last_rs1 <= rd_rs1;
                last_rs2 <= rd_rs2;
                z1_q     <= (rd_rs1 == 5'd0);
                z2_q     <= (rd_rs2 == 5'd0);
            end
        end
    end

`ifdef RF_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflict_cnt <= 16'd0;
            perf_force_cnt    <= 16'd0;
        end else begin
            if (wr_valid && rd_valid && perf_conflict_cnt != 16'hFFFF)
                perf_conflict_cnt <= perf_conflict_cnt + 16'd1;
            // Counts only reads that won over a pending write.
            if (rd_gnt && force_rd && wr_valid && perf_force_cnt != 16'hFFFF)
                perf_force_cnt <= perf_force_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter
//   Bench for rf_port_arbiter with a behavioural 1-cycle registered
//   register file attached. Directed per-cycle vectors plus a reset
//   sequence. Define RF_ARB_PERF_EN to also cover the perf counters.
module tb_rf_port_arbiter;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  rd_rs1;
    logic [4:0]  rd_rs2;
    logic        rsp_valid;
    logic [31:0] rsp_data1;
    logic [31:0] rsp_data2;
    logic        rf_write;
    logic [31:0] rf_write_data;
    logic [4:0]  rf_rd;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [31:0] rf_out1;
    logic [31:0] rf_out2;
    logic [1:0]  state_dbg;
`ifdef RF_ARB_PERF_EN
    logic [15:0] perf_conflict_cnt;
    logic [15:0] perf_force_cnt;
`endif

    rf_port_arbiter #(.MAX_WR_STREAK(4), .STREAK_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_rd         (wr_rd),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_rs1        (rd_rs1),
        .rd_rs2        (rd_rs2),
        .rsp_valid     (rsp_valid),
        .rsp_data1     (rsp_data1),
        .rsp_data2     (rsp_data2),
        .rf_write      (rf_write),
        .rf_write_data (rf_write_data),
        .rf_rd         (rf_rd),
        .rf_rs1        (rf_rs1),
        .rf_rs2        (rf_rs2),
        .rf_out1       (rf_out1),
        .rf_out2       (rf_out2),
        .state_dbg     (state_dbg)
`ifdef RF_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_force_cnt    (perf_force_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- register file model ----------------
    logic [31:0] rf_mem [32];
    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        rf_out1 = 32'd0;
        rf_out2 = 32'd0;
    end
    always @(posedge clk) begin
        if (rf_write) begin
            rf_mem[rf_rd] <= rf_write_data;
        end else begin
            rf_out1 <= rf_mem[rf_rs1];
            rf_out2 <= rf_mem[rf_rs2];
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] shadow [32];
    initial for (int i = 0; i < 32; i++) shadow[i] = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares a response against the oldest expected read, then records
    // any newly granted read/write in the shadow register image.
    task automatic scoreboard_step();
        logic [63:0] e;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_rsp_data", {rsp_data1, rsp_data2}, e);
            end
        end
        if (rd_valid && rd_ready)
            exp_q.push_back({shadow[rd_rs1], shadow[rd_rs2]});
        if (wr_valid && wr_ready && wr_rd != 5'd0)
            shadow[wr_rd] = wr_data;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        rv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_wr;
        logic        e_rd;
        logic        e_rfw;
        logic        e_rsp;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic wv, input logic [4:0] wrd, input logic [31:0] wdata,
                                input logic rv, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic e_wr, input logic e_rd, input logic e_rfw,
                                input logic e_rsp, input logic [31:0] e_d1, input logic [31:0] e_d2);
        vec_t v;
        v.wv = wv; v.wrd = wrd; v.wdata = wdata;
        v.rv = rv; v.rs1 = rs1; v.rs2 = rs2;
        v.e_wr = e_wr; v.e_rd = e_rd; v.e_rfw = e_rfw;
        v.e_rsp = e_rsp; v.e_d1 = e_d1; v.e_d2 = e_d2;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        wr_valid = 1'b0; wr_rd = 5'd0; wr_data = 32'd0;
        rd_valid = 1'b0; rd_rs1 = 5'd0; rd_rs2 = 5'd0;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        string tag;
        @(negedge clk);
        wr_valid = v.wv; wr_rd = v.wrd; wr_data = v.wdata;
        rd_valid = v.rv; rd_rs1 = v.rs1; rd_rs2 = v.rs2;
        #1;
        tag = $sformatf("v%0d", idx);
        check({tag, "_wr_ready"}, {63'd0, wr_ready}, {63'd0, v.e_wr});
        check({tag, "_rd_ready"}, {63'd0, rd_ready}, {63'd0, v.e_rd});
        check({tag, "_rf_write"}, {63'd0, rf_write}, {63'd0, v.e_rfw});
        check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, {63'd0, v.e_rsp});
        check({tag, "_rsp_data"}, {rsp_data1, rsp_data2}, {v.e_d1, v.e_d2});
        scoreboard_step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"}, {63'd0, wr_ready}, 64'd0);
        check({tag, "_rd_ready"}, {63'd0, rd_ready}, 64'd0);
        check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "_rsp_data"}, {rsp_data1, rsp_data2}, 64'd0);
        check({tag, "_rf_ctl"}, {58'd0, rf_write, rf_rd}, 64'd0);
        check({tag, "_rf_wdata"}, {32'd0, rf_write_data}, 64'd0);
        check({tag, "_rf_rs"}, {54'd0, rf_rs1, rf_rs2}, 64'd0);
        check({tag, "_state"}, {62'd0, state_dbg}, 64'd0);
`ifdef RF_ARB_PERF_EN
        check({tag, "_perf"}, {32'd0, perf_conflict_cnt, perf_force_cnt}, 64'd0);
`endif
    endtask

    // ---------------- test ----------------
    initial begin
        // Write x5, read x5/x0.
        vecs[0]  = mk(1,5,32'hDEADBEEF, 0,0,0, 1,0,1, 0,0,0);
        vecs[1]  = mk(0,0,0,            1,5,0, 0,1,0, 0,0,0);
        vecs[2]  = mk(0,0,0,            0,0,0, 0,0,0, 1,32'hDEADBEEF,0);
        // Write to x0 is accepted but dropped; reading x0 yields 0.
        vecs[3]  = mk(1,0,32'h1234,     0,0,0, 1,0,0, 0,0,0);
        vecs[4]  = mk(0,0,0,            1,0,5, 0,1,0, 0,0,0);
        vecs[5]  = mk(0,0,0,            0,0,0, 0,0,0, 1,0,32'hDEADBEEF);
        // Same-cycle write/read of x3: write first, read sees new value.
        vecs[6]  = mk(1,3,32'hA5A5A5A5, 1,3,3, 1,0,1, 0,0,0);
        vecs[7]  = mk(0,0,0,            1,3,3, 0,1,0, 0,0,0);
        vecs[8]  = mk(0,0,0,            0,0,0, 0,0,0, 1,32'hA5A5A5A5,32'hA5A5A5A5);
        // Preload then three back-to-back reads.
        vecs[9]  = mk(1,1,32'd11,       0,0,0, 1,0,1, 0,0,0);
        vecs[10] = mk(1,2,32'd22,       0,0,0, 1,0,1, 0,0,0);
        vecs[11] = mk(1,3,32'd33,       0,0,0, 1,0,1, 0,0,0);
        vecs[12] = mk(0,0,0,            1,1,2, 0,1,0, 0,0,0);
        vecs[13] = mk(0,0,0,            1,2,3, 0,1,0, 1,32'd11,32'd22);
        vecs[14] = mk(0,0,0,            1,3,1, 0,1,0, 1,32'd22,32'd33);
        vecs[15] = mk(0,0,0,            0,0,0, 0,0,0, 1,32'd33,32'd11);
        // Sustained contention: W W W W R W W W W R.
        vecs[16] = mk(1,7,32'h77,       1,7,0, 1,0,1, 0,0,0);
        vecs[17] = mk(1,7,32'h77,       1,7,0, 1,0,1, 0,0,0);
        vecs[18] = mk(1,7,32'h77,       1,7,0, 1,0,1, 0,0,0);
        vecs[19] = mk(1,7,32'h77,       1,7,0, 1,0,1, 0,0,0);
        vecs[20] = mk(1,7,32'h77,       1,7,0, 0,1,0, 0,0,0);
        vecs[21] = mk(1,7,32'h77,       1,7,0, 1,0,1, 1,32'h77,0);
        vecs[22] = mk(1,7,32'h77,       1,7,0, 1,0,1, 0,0,0);
        vecs[23] = mk(1,7,32'h77,       1,7,0, 1,0,1, 0,0,0);
        vecs[24] = mk(1,7,32'h77,       1,7,0, 1,0,1, 0,0,0);
        vecs[25] = mk(1,7,32'h77,       1,7,0, 0,1,0, 0,0,0);
        vecs[26] = mk(0,0,0,            0,0,0, 0,0,0, 1,32'h77,0);

        // Reset with both requesters asserted: nothing may be granted.
        rst = 1'b1;
        drive_idle();
        wr_valid = 1'b1; wr_rd = 5'd9; wr_data = 32'h55;
        rd_valid = 1'b1; rd_rs1 = 5'd9;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst0");
        drive_idle();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) apply_vec(i, vecs[i]);
        check("sb_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef RF_ARB_PERF_EN
        #1;
        check("perf_conflict", {48'd0, perf_conflict_cnt}, 64'd11);
        check("perf_force", {48'd0, perf_force_cnt}, 64'd2);
`endif

        // Reset right after a read grant kills the pending response.
        @(negedge clk);
        rd_valid = 1'b1; rd_rs1 = 5'd1; rd_rs2 = 5'd2;
        #1;
        check("rstseq_rd_ready", {63'd0, rd_ready}, 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        wr_valid = 1'b1; wr_rd = 5'd4; wr_data = 32'h99;
        #1;
        check_reset_outputs("rst1");
        exp_q.delete();
        @(negedge clk);
        #1;
        check_reset_outputs("rst2");
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstseq_rsp_after", {63'd0, rsp_valid}, 64'd0);

        // Register file must not have been written during reset.
        check("rstseq_x4_untouched", {32'd0, rf_mem[4]}, 64'd0);

        // Post-reset read of x1 still works.
        @(negedge clk);
        rd_valid = 1'b1; rd_rs1 = 5'd1; rd_rs2 = 5'd0;
        #1;
        check("post_rd_ready", {63'd0, rd_ready}, 64'd1);
        @(negedge clk);
        drive_idle();
        #1;
        check("post_rsp", {31'd0, rsp_valid, rsp_data1}, {31'd0, 1'b1, 32'd11});

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
Arbiter/sequencer in front of the single-port register file (one read-pair or one write per clock edge). Shares the register file between the writeback stage (write requester) and the decode stage (read requester) using valid/ready handshakes. Drives the register file's write/address/data inputs and returns read data as a one-cycle response pulse. Guarantees no read starves under sustained writeback.

Parameters:
MAX_WR_STREAK, 4, consecutive write grants allowed while a read is waiting before the read is forced through (1..7)
STREAK_W, 3, width of the streak counter; must hold MAX_WR_STREAK

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-high reset
wr_valid  in  1  writeback request
wr_ready  out  1  write granted this cycle (combinational)
wr_rd  in  5  destination register
wr_data  in  32  write data
rd_valid  in  1  decode read request
rd_ready  out  1  read granted this cycle (combinational)
rd_rs1  in  5  source register 1
rd_rs2  in  5  source register 2
rsp_valid  out  1  read response valid, one-cycle pulse
rsp_data1  out  32  Reg[rs1] for the granted read
rsp_data2  out  32  Reg[rs2] for the granted read
rf_write  out  1  to register file write (0 = read)
rf_write_data  out  32  to register file write_data
rf_rd  out  5  to register file rd
rf_rs1  out  5  to register file rs1
rf_rs2  out  5  to register file rs2
rf_out1  in  32  from register file out1
rf_out2  in  32  from register file out2

Behaviour:
- Register file is 1-cycle registered: read addressed in cycle N gives rf_out in cycle N+1; rf_out holds during write cycles.
- Transfer = valid && ready in the same cycle. Ready may depend on valid. Requesters hold valid and payload until accepted.
- Grant each cycle (combinational):
  - write if wr_valid && !(rd_valid && streak == MAX_WR_STREAK);
  - else read if rd_valid;
  - else idle.
  - At most one of wr_ready/rd_ready high.
- Streak counter:
  - +1 on a write grant while rd_valid=1, saturating at MAX_WR_STREAK;
  - cleared on any read grant, or on any cycle with rd_valid=0.
- Write grant: rf_write=1, rf_rd=wr_rd, rf_write_data=wr_data.
  - Write to x0 (wr_rd==0) is accepted (wr_ready=1) but rf_write held 0; no register changes.
- Read grant: rf_write=0, rf_rs1/rf_rs2 = rd_rs1/rd_rs2.
  - Registered flags capture (rs1==0) and (rs2==0).
  - rsp_valid=1 in cycle N+1 only. rsp_data1/2 = rf_out1/2, forced to 0 where the captured flag is set.
  - No response backpressure; decode samples the pulse.
- Idle/write cycles: rf_rs1/rf_rs2 hold their last read addresses. rsp_valid=0. rsp_data1/2 = 0 when rsp_valid=0.
- Same-cycle write and read with matching rd/rs: write wins. The read is granted in a later cycle and sees the new value (write lands at edge N, read at edge N+1 or later).
- Back-to-back reads: one accepted per cycle, one rsp_valid per cycle, in order.
- FSM (registered): IDLE, WRITE, READ = the grant issued in the previous cycle.
  - rsp_valid = (state==READ).
  - Any state goes to WRITE/READ/IDLE per the grant rule.
- Reset (async, any time):
  - state=IDLE, streak=0, rsp_valid=0, zero flags=0.
  - rf_write=0, rf_rs1=rf_rs2=rf_rd=0, rf_write_data=0.
  - A read granted in the reset cycle produces no response.
  - Outputs are combinational from the held-zero state while rst=1: wr_ready=rd_ready=0 during reset.

Optional Feature:
RF_ARB_PERF_EN:
- Defined: adds output perf_conflict_cnt[15:0] (cycles with wr_valid && rd_valid) and output perf_force_cnt[15:0] (reads granted because streak hit MAX_WR_STREAK).
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Write x5=32'hDEADBEEF, then read rs1=5, rs2=0 -> wr_ready 1 cycle, rd_ready next cycle, rsp_valid one cycle later with data1=32'hDEADBEEF, data2=0.
- Write x0=32'h1234, then read rs1=0 -> rf_write stays 0, wr_ready=1, rsp_data1=0.
- wr_valid held high 10 cycles with rd_valid high, MAX_WR_STREAK=4 -> grants W,W,W,W,R, then W resumes; streak back to 0 after the read.
- Same-cycle wr(rd=3, 32'hA5A5A5A5) and rd(rs1=3) -> write granted first, read next cycle returns 32'hA5A5A5A5.
- Reads rs1=1,2,3 in consecutive cycles after preloading 11,22,33 -> three consecutive rsp_valid pulses with data1=11,22,33 in order.
- rst asserted the cycle after a read grant -> rsp_valid stays 0, all rf_* outputs 0, wr_ready/rd_ready 0 until release; with RF_ARB_PERF_EN both counters read 0.
